// File: rtl/gpr_wb_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_arb_if
// Description : Bundle of the writeback arbiter's producer handshakes, GPR
//               write port and pending-write query signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpr_wb_arb_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    // execute producer
    logic          ex_val;
    logic          ex_rdy;
    logic [AW-1:0] ex_adr;
    logic [DW-1:0] ex_dat;
    // load producer
    logic          ld_val;
    logic          ld_rdy;
    logic [AW-1:0] ld_adr;
    logic [DW-1:0] ld_dat;
    // GPR write port
    logic          wr_en_0;
    logic [AW-1:0] wr_adr_0;
    logic [DW-1:0] wr_dat_0;
    // pending-write query and status
    logic [AW-1:0] chk_adr;
    logic          chk_pend;
    logic          idle;
    logic          conflict;

    // Arbiter side
    modport slave (
        input  ex_val, ex_adr, ex_dat, ld_val, ld_adr, ld_dat, chk_adr,
        output ex_rdy, ld_rdy, wr_en_0, wr_adr_0, wr_dat_0, chk_pend, idle, conflict
    );

    // Producer / GPR / operand-fetch side
    modport master (
        output ex_val, ex_adr, ex_dat, ld_val, ld_adr, ld_dat, chk_adr,
        input  ex_rdy, ld_rdy, wr_en_0, wr_adr_0, wr_dat_0, chk_pend, idle, conflict
    );
endinterface
`default_nettype wire

// File: rtl/gpr_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_arb
// Description : Two-source (execute/load) GPR writeback arbiter. Each source
//               has its own FIFO; round-robin grant drives one registered
//               write per cycle and reports in-flight writes per GPR.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_wb_arb #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    gpr_wb_arb_if.slave bus
);
    localparam int             c_IW  = $clog2(DEPTH);
    localparam int             c_PW  = c_IW + 1;
    localparam logic [c_PW-1:0] c_ONE = c_PW'(1);
    // Source index 0 is execute, 1 is load.

    logic [AW-1:0]    r_mem_adr [2][DEPTH];
    logic [DW-1:0]    r_mem_dat [2][DEPTH];
    logic [DEPTH-1:0] r_vld     [2];
    logic [c_PW-1:0]  r_wp      [2];
    logic [c_PW-1:0]  r_rp      [2];
    logic             r_last_ld;
    logic             r_wr_en;
    logic [AW-1:0]    r_wr_adr;
    logic [DW-1:0]    r_wr_dat;
    logic             r_conflict;

    logic [1:0]       w_val;
    logic [AW-1:0]    w_in_adr  [2];
    logic [DW-1:0]    w_in_dat  [2];
    logic [AW-1:0]    w_head_adr[2];
    logic [DW-1:0]    w_head_dat[2];
    logic [1:0]       w_empty;
    logic [1:0]       w_full;
    logic [1:0]       w_rdy;
    logic [1:0]       w_push;
    logic [1:0]       w_gnt;
    logic             w_pend;
    logic             w_ex_hit;
    logic             w_ld_hit;
    logic             w_conflict;

    // FIFO status, handshake and head-of-queue selection per source
    always_comb begin
        w_val       = {bus.ld_val, bus.ex_val};
        w_in_adr[0] = bus.ex_adr;
        w_in_adr[1] = bus.ld_adr;
        w_in_dat[0] = bus.ex_dat;
        w_in_dat[1] = bus.ld_dat;
        for (int s = 0; s < 2; s++) begin
            w_empty[s]    = (r_wp[s] == r_rp[s]);
            w_full[s]     = (r_wp[s][c_IW] != r_rp[s][c_IW]) &&
                            (r_wp[s][c_IW-1:0] == r_rp[s][c_IW-1:0]);
            // rdy is held low during reset; full alone governs it afterwards,
            // so a full FIFO never accepts even while being popped.
            w_rdy[s]      = ~rst & ~w_full[s];
            w_push[s]     = w_val[s] & w_rdy[s];
            w_head_adr[s] = r_mem_adr[s][r_rp[s][c_IW-1:0]];
            w_head_dat[s] = r_mem_dat[s][r_rp[s][c_IW-1:0]];
        end
    end

    // Round-robin grant: a lone non-empty FIFO wins, ties go to the source not granted last
    always_comb begin
        w_gnt    = 2'b00;
        w_gnt[0] = ~w_empty[0] & (w_empty[1] | r_last_ld);
        w_gnt[1] = ~w_empty[1] & ~w_gnt[0];
    end

    // Pending-write lookup and cross-source duplicate detection over valid entries
    always_comb begin
        w_pend   = r_wr_en && (r_wr_adr == bus.chk_adr);
        w_ex_hit = 1'b0;
        w_ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (r_vld[s][i] && (r_mem_adr[s][i] == bus.chk_adr)) begin
                    w_pend = 1'b1;
                end
            end
            if (r_vld[1][i] && (r_mem_adr[1][i] == w_in_adr[0])) begin
                w_ex_hit = 1'b1;
            end
            if (r_vld[0][i] && (r_mem_adr[0][i] == w_in_adr[1])) begin
                w_ld_hit = 1'b1;
            end
        end
        w_conflict = (w_push[0] & w_ex_hit) | (w_push[1] & w_ld_hit) |
                     (w_push[0] & w_push[1] & (w_in_adr[0] == w_in_adr[1]));
    end

    // FIFO pointers and per-slot valid bits; reset discards everything queued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                r_wp[s]  <= '0;
                r_rp[s]  <= '0;
                r_vld[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) begin
                    r_wp[s]                      <= r_wp[s] + c_ONE;
                    r_vld[s][r_wp[s][c_IW-1:0]]  <= 1'b1;
                end
                if (w_gnt[s]) begin
                    r_rp[s]                      <= r_rp[s] + c_ONE;
                    r_vld[s][r_rp[s][c_IW-1:0]]  <= 1'b0;
                end
            end
        end
    end

    // FIFO payload storage; contents are only meaningful under a valid bit
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (w_push[s]) begin
                r_mem_adr[s][r_wp[s][c_IW-1:0]] <= w_in_adr[s];
                r_mem_dat[s][r_wp[s][c_IW-1:0]] <= w_in_dat[s];
            end
        end
    end

    // Registered GPR write port, last-grant tracking and sticky conflict flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en    <= 1'b0;
            r_wr_adr   <= '0;
            r_wr_dat   <= '0;
            r_last_ld  <= 1'b1;
            r_conflict <= 1'b0;
        end else begin
            r_wr_en <= |w_gnt;
            if (w_gnt[0]) begin
                r_wr_adr  <= w_head_adr[0];
                r_wr_dat  <= w_head_dat[0];
                r_last_ld <= 1'b0;
            end else if (w_gnt[1]) begin
                r_wr_adr  <= w_head_adr[1];
                r_wr_dat  <= w_head_dat[1];
                r_last_ld <= 1'b1;
            end
            if (w_conflict) begin
                r_conflict <= 1'b1;
            end
        end
    end

    assign bus.ex_rdy   = w_rdy[0];
    assign bus.ld_rdy   = w_rdy[1];
    assign bus.wr_en_0  = r_wr_en;
    assign bus.wr_adr_0 = r_wr_adr;
    assign bus.wr_dat_0 = r_wr_dat;
    assign bus.chk_pend = w_pend;
    assign bus.idle     = w_empty[0] & w_empty[1] & ~r_wr_en;
    assign bus.conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_wb_arb
// Description : Self-checking bench for gpr_wb_arb: table-driven single
//               writes, directed multi-cycle sequences and a randomized run
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_arb;
    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct {
        bit            src;      // 0 = execute, 1 = load
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [AW-1:0] exp_adr;
        logic [DW-1:0] exp_dat;
    } vec_t;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    // reference model state
    ent_t          mq_ex[$];
    ent_t          mq_ld[$];
    bit            m_last_ld;
    bit            m_wr_en;
    logic [AW-1:0] m_wr_adr;
    logic [DW-1:0] m_wr_dat;
    int            m_pushes;
    int            dut_writes;

    vec_t tbl[4];

    always #5 clk = ~clk;

    gpr_wb_arb_if #(.AW(AW), .DW(DW)) bus ();

    gpr_wb_arb #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq_ex.delete();
        mq_ld.delete();
        m_last_ld  = 1'b1;
        m_wr_en    = 1'b0;
        m_wr_adr   = '0;
        m_wr_dat   = '0;
        m_pushes   = 0;
        dut_writes = 0;
    endtask

    task automatic quiet_inputs();
        bus.ex_val  = 1'b0;
        bus.ld_val  = 1'b0;
        bus.ex_adr  = '0;
        bus.ld_adr  = '0;
        bus.ex_dat  = '0;
        bus.ld_dat  = '0;
        bus.chk_adr = '0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        #1;
        check("rst_ex_rdy", bus.ex_rdy, 1'b0);
        check("rst_ld_rdy", bus.ld_rdy, 1'b0);
        check("rst_wr_en", bus.wr_en_0, 1'b0);
        check("rst_conflict", bus.conflict, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check("post_rst_ex_rdy", bus.ex_rdy, 1'b1);
        check("post_rst_ld_rdy", bus.ld_rdy, 1'b1);
        check("post_rst_idle", bus.idle, 1'b1);
    endtask

    task automatic push_one(input bit src, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        if (src) begin
            bus.ld_val = 1'b1; bus.ld_adr = adr; bus.ld_dat = dat;
        end else begin
            bus.ex_val = 1'b1; bus.ex_adr = adr; bus.ex_dat = dat;
        end
    endtask

    task automatic check_write(input string name, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        check({name, "_en"}, bus.wr_en_0, 1'b1);
        check({name, "_adr"}, bus.wr_adr_0, adr);
        check({name, "_dat"}, bus.wr_dat_0, dat);
    endtask

    // One cycle of stimulus compared against the queue model, then advance both.
    task automatic model_cycle(input bit ev, input bit lv, input logic [AW-1:0] ca);
        ent_t ein;
        ent_t lin;
        bit   erdy;
        bit   lrdy;
        bit   pend;
        int   g;
        ein.adr = AW'($urandom_range(0, 7));
        ein.dat = $urandom;
        lin.adr = AW'($urandom_range(0, 7));
        lin.dat = $urandom;
        bus.ex_val = ev; bus.ex_adr = ein.adr; bus.ex_dat = ein.dat;
        bus.ld_val = lv; bus.ld_adr = lin.adr; bus.ld_dat = lin.dat;
        bus.chk_adr = ca;
        #1;
        erdy = (mq_ex.size() < DEPTH);
        lrdy = (mq_ld.size() < DEPTH);
        pend = m_wr_en && (m_wr_adr == ca);
        foreach (mq_ex[i]) if (mq_ex[i].adr == ca) pend = 1'b1;
        foreach (mq_ld[i]) if (mq_ld[i].adr == ca) pend = 1'b1;
        check("m_ex_rdy", bus.ex_rdy, erdy);
        check("m_ld_rdy", bus.ld_rdy, lrdy);
        check("m_chk_pend", bus.chk_pend, pend);
        check("m_wr_en", bus.wr_en_0, m_wr_en);
        if (m_wr_en) begin
            check("m_wr_adr", bus.wr_adr_0, m_wr_adr);
            check("m_wr_dat", bus.wr_dat_0, m_wr_dat);
        end
        if (bus.wr_en_0 === 1'b1) dut_writes++;
        g = -1;
        if (mq_ex.size() > 0 && (mq_ld.size() == 0 || m_last_ld)) g = 0;
        else if (mq_ld.size() > 0) g = 1;
        m_wr_en = (g >= 0);
        if (g == 0) begin
            m_wr_adr = mq_ex[0].adr; m_wr_dat = mq_ex[0].dat;
            void'(mq_ex.pop_front());
            m_last_ld = 1'b0;
        end else if (g == 1) begin
            m_wr_adr = mq_ld[0].adr; m_wr_dat = mq_ld[0].dat;
            void'(mq_ld.pop_front());
            m_last_ld = 1'b1;
        end
        if (ev && erdy) begin mq_ex.push_back(ein); m_pushes++; end
        if (lv && lrdy) begin mq_ld.push_back(lin); m_pushes++; end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] qa;

        tbl[0] = '{src: 1'b0, adr: 5'd5,  dat: 32'hDEADBEEF, exp_adr: 5'd5,  exp_dat: 32'hDEADBEEF};
        tbl[1] = '{src: 1'b1, adr: 5'd0,  dat: 32'h00000000, exp_adr: 5'd0,  exp_dat: 32'h00000000};
        tbl[2] = '{src: 1'b0, adr: 5'd31, dat: 32'hFFFFFFFF, exp_adr: 5'd31, exp_dat: 32'hFFFFFFFF};
        tbl[3] = '{src: 1'b1, adr: 5'd17, dat: 32'h12345678, exp_adr: 5'd17, exp_dat: 32'h12345678};

        do_reset();

        // single writes: two-edge latency and chk_pend over the whole flight
        for (int k = 0; k < 4; k++) begin
            push_one(tbl[k].src, tbl[k].adr, tbl[k].dat);
            bus.chk_adr = tbl[k].exp_adr;
            tick();
            quiet_inputs();
            bus.chk_adr = tbl[k].exp_adr;
            #1;
            check("single_queued_en", bus.wr_en_0, 1'b0);
            check("single_queued_pend", bus.chk_pend, 1'b1);
            tick();
            check_write("single_wr", tbl[k].exp_adr, tbl[k].exp_dat);
            check("single_wr_pend", bus.chk_pend, 1'b1);
            tick();
            check("single_done_en", bus.wr_en_0, 1'b0);
            check("single_done_pend", bus.chk_pend, 1'b0);
            check("single_done_idle", bus.idle, 1'b1);
        end

        // contention: ex r1,r2 and ld r3,r4 interleave as r1,r3,r2,r4
        do_reset();
        push_one(1'b0, 5'd1, 32'h101);
        push_one(1'b1, 5'd3, 32'h103);
        tick();
        push_one(1'b0, 5'd2, 32'h102);
        push_one(1'b1, 5'd4, 32'h104);
        tick();
        quiet_inputs();
        #1;
        check_write("cont_w1", 5'd1, 32'h101);
        tick();
        check_write("cont_w2", 5'd3, 32'h103);
        tick();
        check_write("cont_w3", 5'd2, 32'h102);
        tick();
        check_write("cont_w4", 5'd4, 32'h104);
        tick();
        check("cont_end_en", bus.wr_en_0, 1'b0);
        check("cont_no_conflict", bus.conflict, 1'b0);

        // conflict: ex r7 queued, ld r7 pushed next cycle
        push_one(1'b0, 5'd7, 32'hE7);
        tick();
        quiet_inputs();
        push_one(1'b1, 5'd7, 32'hA7);
        #1;
        check("conf_before", bus.conflict, 1'b0);
        tick();
        quiet_inputs();
        #1;
        check("conf_set", bus.conflict, 1'b1);
        check_write("conf_w_ex", 5'd7, 32'hE7);
        tick();
        check_write("conf_w_ld", 5'd7, 32'hA7);
        repeat (3) tick();
        check("conf_sticky", bus.conflict, 1'b1);
        check("conf_idle", bus.idle, 1'b1);

        // full: ld held valid while ex traffic competes for the port
        do_reset();
        model_cycle(1'b1, 1'b1, 5'd0);
        model_cycle(1'b1, 1'b1, 5'd1);
        check("full_ld_rdy", bus.ld_rdy, 1'b0);
        check("full_ex_rdy", bus.ex_rdy, 1'b1);
        for (int k = 0; k < 10; k++) model_cycle(1'b1, 1'b1, AW'(k % 8));
        for (int k = 0; k < 8; k++) model_cycle(1'b0, 1'b0, AW'(k));
        check("full_count", dut_writes, m_pushes);
        check("full_idle", bus.idle, 1'b1);

        // reset mid-traffic with 2 ex + 1 ld queued and a write on the port
        do_reset();
        model_cycle(1'b1, 1'b1, 5'd0);
        model_cycle(1'b1, 1'b1, 5'd0);
        model_cycle(1'b1, 1'b0, 5'd0);
        qa = (mq_ex.size() > 0) ? mq_ex[0].adr : 5'd0;
        quiet_inputs();
        bus.chk_adr = qa;
        rst = 1'b1;
        #1;
        check("midrst_wr_en", bus.wr_en_0, 1'b0);
        check("midrst_wr_adr", bus.wr_adr_0, 5'd0);
        check("midrst_pend", bus.chk_pend, 1'b0);
        check("midrst_idle", bus.idle, 1'b1);
        check("midrst_ex_rdy", bus.ex_rdy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) model_cycle(1'b0, 1'b0, qa);
        check("midrst_no_writes", dut_writes, 0);
        check("midrst_idle_after", bus.idle, 1'b1);

        // randomized traffic against the queue model
        do_reset();
        for (int k = 0; k < 10000; k++) begin
            model_cycle($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 45,
                        AW'($urandom_range(0, 7)));
        end
        for (int k = 0; k < 8; k++) model_cycle(1'b0, 1'b0, AW'(k));
        check("rand_write_count", dut_writes, m_pushes);
        check("rand_idle", bus.idle, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
